// File: rtl/proc_pkg.sv
// Shared definitions for the processor-side blocks: opcodes, instruction
// field positions and the feeder state encoding.
package proc_pkg;

  localparam int WORD_W = 9;

  localparam int I_MSB = 8;
  localparam int I_LSB = 6;
  localparam int X_MSB = 5;
  localparam int X_LSB = 3;
  localparam int Y_MSB = 2;
  localparam int Y_LSB = 0;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_IMM   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HALT  = 3'd5
  } feeder_state_t;

  function automatic logic [2:0] opcode_of(input logic [WORD_W-1:0] w);
    return w[I_MSB:I_LSB];
  endfunction

  function automatic logic [2:0] xreg_of(input logic [WORD_W-1:0] w);
    return w[X_MSB:X_LSB];
  endfunction

  function automatic logic [2:0] yreg_of(input logic [WORD_W-1:0] w);
    return w[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/prog_mem.sv
// DEPTH x WIDTH storage array: synchronous write, combinational read.
// Contents are deliberately not reset so a loaded program survives Resetn.
module prog_mem
  import proc_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int WIDTH  = WORD_W
) (
  input  logic              Clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/proc_feeder.sv
// Initiator for the processor's DIN/Run/Done interface: steps through a
// loadable program, issuing each word (plus the mvi immediate) and waiting for Done.
module proc_feeder
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              ProgWe,
  input  logic [ADDR_W-1:0] ProgAddr,
  input  logic [WORD_W-1:0] ProgData,
  input  logic              Done,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic [15:0]       InstrCount,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  feeder_state_t     state_reg, state_next;
  logic [WORD_W-1:0] din_reg, din_next;
  logic              run_reg, run_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [15:0]       cnt_reg, cnt_next;
  logic              busy_reg, busy_next;
  logic              halted_reg, halted_next;
  logic              err_reg, err_next;
  logic [TMR_W-1:0]  tmr_reg, tmr_next;
  logic              mvi_reg, mvi_next;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_raddr;
  logic [WORD_W-1:0] mem_rdata;

  function automatic logic [ADDR_W-1:0] pc_add(input logic [ADDR_W-1:0] pc, input int n);
    int sum;
    sum = (int'(pc) + n) % DEPTH;
    return ADDR_W'(sum);
  endfunction

  prog_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .WIDTH  (WORD_W)
  ) u_prog_mem (
    .Clock (Clock),
    .we    (mem_we),
    .waddr (ProgAddr),
    .wdata (ProgData),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg  <= ST_IDLE;
      din_reg    <= '0;
      run_reg    <= 1'b0;
      pc_reg     <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      halted_reg <= 1'b0;
      err_reg    <= 1'b0;
      tmr_reg    <= '0;
      mvi_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      din_reg    <= din_next;
      run_reg    <= run_next;
      pc_reg     <= pc_next;
      cnt_reg    <= cnt_next;
      busy_reg   <= busy_next;
      halted_reg <= halted_next;
      err_reg    <= err_next;
      tmr_reg    <= tmr_next;
      mvi_reg    <= mvi_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    din_next   = din_reg;
    run_next   = run_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    tmr_next   = tmr_reg;
    mvi_next   = mvi_reg;
    mem_we     = 1'b0;
    mem_raddr  = pc_reg;

    case (state_reg)
      ST_IDLE, ST_HALT: begin
        // A write in the same cycle as Start takes priority; Start is dropped.
        if (ProgWe) begin
          mem_we = 1'b1;
        end else if (Start) begin
          pc_next    = '0;
          err_next   = 1'b0;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (opcode_of(mem_rdata) == OP_HALT) begin
          state_next = ST_HALT;
        end else begin
          din_next   = mem_rdata;
          run_next   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_next = '0;
        mvi_next = (opcode_of(din_reg) == OP_MVI);
        if (opcode_of(din_reg) == OP_MVI) begin
          mem_raddr  = pc_add(pc_reg, 1);
          din_next   = mem_rdata;
          state_next = ST_IMM;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_IMM: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (Done) begin
          run_next   = 1'b0;
          din_next   = '0;
          cnt_next   = cnt_reg + 16'd1;
          pc_next    = pc_add(pc_reg, mvi_reg ? 2 : 1);
          state_next = ST_FETCH;
        end else if (tmr_reg == TMR_W'(TIMEOUT - 1)) begin
          // Last permitted WAIT cycle passed without Done: give up.
          err_next   = 1'b1;
          run_next   = 1'b0;
          din_next   = '0;
          state_next = ST_HALT;
        end else begin
          tmr_next = tmr_reg + TMR_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next   = state_next inside {ST_FETCH, ST_ISSUE, ST_IMM, ST_WAIT};
    halted_next = (state_next == ST_HALT);
  end

  assign DIN        = din_reg;
  assign Run        = run_reg;
  assign PC         = pc_reg;
  assign InstrCount = cnt_reg;
  assign Busy       = busy_reg;
  assign Halted     = halted_reg;
  assign Error      = err_reg;

endmodule

// File: tb/tb_proc_feeder.sv
// Directed + randomized bench for proc_feeder; expected behaviour comes from a
// program-level model that walks the loaded program instruction by instruction.
module tb_proc_feeder;

  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 15;

  logic              Clock    = 1'b0;
  logic              Resetn   = 1'b0;
  logic              Start    = 1'b0;
  logic              ProgWe   = 1'b0;
  logic [ADDR_W-1:0] ProgAddr = '0;
  logic [8:0]        ProgData = '0;
  logic              Done     = 1'b0;
  logic [8:0]        DIN;
  logic              Run;
  logic [ADDR_W-1:0] PC;
  logic [15:0]       InstrCount;
  logic              Busy;
  logic              Halted;
  logic              Error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] mdl_mem [DEPTH];
  int         mdl_pc  = 0;
  int         mdl_cnt = 0;

  proc_feeder #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Start      (Start),
    .ProgWe     (ProgWe),
    .ProgAddr   (ProgAddr),
    .ProgData   (ProgData),
    .Done       (Done),
    .DIN        (DIN),
    .Run        (Run),
    .PC         (PC),
    .InstrCount (InstrCount),
    .Busy       (Busy),
    .Halted     (Halted),
    .Error      (Error)
  );

  always #5 Clock = ~Clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [8:0] d);
    @(negedge Clock);
    ProgWe   = 1'b1;
    ProgAddr = a[ADDR_W-1:0];
    ProgData = d;
    @(negedge Clock);
    ProgWe   = 1'b0;
    mdl_mem[a] = d;
    $display("load   mem[%0d] = 0x%03h", a, d);
  endtask

  // Leaves the bench at the negedge of the FETCH cycle for PC 0.
  task automatic start_prog();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start  = 1'b0;
    mdl_pc = 0;
    check("start_busy", Busy, 1);
    check("start_run", Run, 0);
    check("start_pc", PC, 0);
    check("start_err", Error, 0);
    check("start_halted", Halted, 0);
    $display("start  pc=0");
  endtask

  // Entered at the FETCH negedge; wt = WAIT cycles before Done is raised.
  task automatic do_instr(input int wt, input bit ign_done, input bit poke, output bit halted);
    logic [8:0] w;
    logic [8:0] imm;
    bit         is_mvi;
    int         npc;
    int         tgt;
    w      = mdl_mem[mdl_pc];
    halted = 1'b0;
    if (w[8:6] == 3'b111) begin
      @(negedge Clock);
      check("halt_halted", Halted, 1);
      check("halt_busy", Busy, 0);
      check("halt_run", Run, 0);
      check("halt_pc", PC, mdl_pc);
      check("halt_cnt", InstrCount, mdl_cnt);
      halted = 1'b1;
      $display("halt   pc=%0d count=%0d", mdl_pc, mdl_cnt);
      return;
    end
    @(negedge Clock);
    check("issue_run", Run, 1);
    check("issue_din", DIN, w);
    check("issue_pc", PC, mdl_pc);
    if (ign_done) Done = 1'b1;
    if (poke) begin
      tgt      = (mdl_pc + 1) % DEPTH;
      Start    = 1'b1;
      ProgWe   = 1'b1;
      ProgAddr = tgt[ADDR_W-1:0];
      ProgData = mdl_mem[tgt] ^ 9'h1FF;
    end
    is_mvi = (w[8:6] == 3'b001);
    imm    = w;
    if (is_mvi) begin
      @(negedge Clock);
      Done = 1'b0; Start = 1'b0; ProgWe = 1'b0;
      imm = mdl_mem[(mdl_pc + 1) % DEPTH];
      check("imm_run", Run, 1);
      check("imm_din", DIN, imm);
    end
    @(negedge Clock);
    Done = 1'b0; Start = 1'b0; ProgWe = 1'b0;
    for (int k = 0; k < wt; k++) begin
      check("wait_run", Run, 1);
      check("wait_din", DIN, imm);
      @(negedge Clock);
    end
    check("wait_run", Run, 1);
    Done = 1'b1;
    @(negedge Clock);
    Done    = 1'b0;
    npc     = (mdl_pc + (is_mvi ? 2 : 1)) % DEPTH;
    mdl_cnt = (mdl_cnt + 1) & 16'hFFFF;
    check("retire_run", Run, 0);
    check("retire_din", DIN, 0);
    check("retire_pc", PC, npc);
    check("retire_cnt", InstrCount, mdl_cnt);
    check("retire_busy", Busy, 1);
    $display("instr  pc=%0d word=0x%03h din2=0x%03h wait=%0d ign=%0d poke=%0d -> pc=%0d count=%0d",
             mdl_pc, w, imm, wt, ign_done, poke, npc, mdl_cnt);
    mdl_pc = npc;
  endtask

  task automatic run_prog(input int max_steps, input int wt, input bit extras);
    bit h;
    int w;
    bit ig;
    bit pk;
    h = 1'b0;
    for (int s = 0; s < max_steps && !h; s++) begin
      w  = (wt < 0) ? int'($urandom_range(0, TIMEOUT - 1)) : wt;
      ig = extras && ($urandom_range(0, 3) == 0);
      pk = extras && ($urandom_range(0, 3) == 0);
      do_instr(w, ig, pk, h);
    end
    check("halt_reached", h, 1);
  endtask

  // Entered at the FETCH negedge of a non-halt instruction; Done never comes.
  task automatic do_timeout();
    logic [8:0] w;
    w = mdl_mem[mdl_pc];
    @(negedge Clock);
    if (w[8:6] == 3'b001) @(negedge Clock);
    @(negedge Clock);
    for (int k = 0; k < TIMEOUT; k++) begin
      check("to_wait_run", Run, 1);
      check("to_wait_err", Error, 0);
      @(negedge Clock);
    end
    check("to_err", Error, 1);
    check("to_halted", Halted, 1);
    check("to_run", Run, 0);
    check("to_din", DIN, 0);
    check("to_busy", Busy, 0);
    check("to_pc", PC, mdl_pc);
    check("to_cnt", InstrCount, mdl_cnt);
    repeat (5) @(negedge Clock);
    check("to_err_sticky", Error, 1);
    $display("timeout pc=%0d error=%0b", mdl_pc, Error);
  endtask

  function automatic logic [8:0] rand_word(input bit allow_mvi);
    logic [2:0] op;
    logic [5:0] xy;
    int r;
    r  = allow_mvi ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 5));
    op = allow_mvi ? 3'(r) : ((r == 0) ? 3'd0 : 3'(r + 1));
    xy = 6'($urandom);
    return {op, xy};
  endfunction

  initial begin
    bit  h;
    int  base;

    // Reset values
    #12;
    check("rst_din", DIN, 0);
    check("rst_run", Run, 0);
    check("rst_pc", PC, 0);
    check("rst_cnt", InstrCount, 0);
    check("rst_busy", Busy, 0);
    check("rst_halted", Halted, 0);
    check("rst_err", Error, 0);
    $display("reset  outputs checked");
    @(negedge Clock);
    Resetn  = 1'b1;
    mdl_cnt = 0;

    // mvi R0, #5 then halt
    load(0, 9'h040);
    load(1, 9'h005);
    load(2, 9'h1C0);
    start_prog();
    run_prog(5, 1, 1'b0);
    check("t1_pc", PC, 2);
    check("t1_cnt", InstrCount, 1);
    check("t1_halted", Halted, 1);

    // add / mv / sub / halt, Done one cycle into WAIT
    load(0, 9'h08A);
    load(1, 9'h011);
    load(2, 9'h0D3);
    load(3, 9'h1C0);
    base = mdl_cnt;
    start_prog();
    run_prog(10, 1, 1'b0);
    check("t2_pc", PC, 3);
    check("t2_cnt", InstrCount, base + 3);

    // Done timeout, then restart clears Error
    load(0, 9'h0D3);
    load(1, 9'h1C0);
    start_prog();
    do_timeout();
    start_prog();
    run_prog(5, 0, 1'b0);

    // mvi at the last address takes its immediate from address 0
    load(0, 9'h048);
    load(1, 9'h1C0);
    for (int a = 2; a < DEPTH - 1; a++) load(a, rand_word(1'b0));
    load(DEPTH - 1, 9'h07A);
    start_prog();
    run_prog(40, 0, 1'b0);
    check("t4_pc", PC, 1);
    check("t4_halted", Halted, 1);

    // Asynchronous reset during IMM, then rerun from intact memory
    load(0, 9'h051);
    load(1, 9'h1AB);
    load(2, 9'h1C0);
    start_prog();
    @(negedge Clock);
    check("t5_issue_din", DIN, 9'h051);
    @(negedge Clock);
    check("t5_imm_din", DIN, 9'h1AB);
    Resetn = 1'b0;
    #1;
    check("t5_rst_run", Run, 0);
    check("t5_rst_din", DIN, 0);
    check("t5_rst_pc", PC, 0);
    check("t5_rst_cnt", InstrCount, 0);
    check("t5_rst_busy", Busy, 0);
    mdl_cnt = 0;
    $display("reset  asserted in IMM");
    @(negedge Clock);
    Resetn = 1'b1;
    check("t5_idle_halted", Halted, 0);
    check("t5_idle_busy", Busy, 0);
    start_prog();
    run_prog(5, 2, 1'b0);
    check("t5_pc", PC, 2);
    check("t5_cnt", InstrCount, 1);

    // Start/ProgWe while busy and Done during ISSUE must be ignored
    load(0, 9'h08A);
    load(1, 9'h059);
    load(2, 9'h123);
    load(3, 9'h011);
    load(4, 9'h1C0);
    start_prog();
    do_instr(2, 1'b1, 1'b1, h);
    do_instr(1, 1'b1, 1'b1, h);
    do_instr(3, 1'b1, 1'b1, h);
    do_instr(0, 1'b0, 1'b0, h);
    check("t6_halted", h, 1);
    check("t6_pc", PC, 4);

    // Random programs with random Done latency and busy-time disturbances
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < DEPTH - 2; a++) load(a, rand_word(1'b1));
      load(DEPTH - 2, rand_word(1'b0));
      load(DEPTH - 1, 9'h1C0);
      start_prog();
      run_prog(40, -1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
